regfile_scoreboard: RTL

- 32-entry integer register file with a per-register pending-write scoreboard.
- Receives the write-back stage outputs (write_data/write_reg/write_enable) and serves two combinational read ports to decode, with same-cycle write-to-read bypass.
- Decode marks destinations pending at issue; write-back retires them. Hazard and issue_ready outputs drive the decode stall logic.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with two bypassed read ports and a per-register
// pending-write counter that drives decode stall and hazard signalling.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    output logic              hazard1,
    output logic              hazard2,
    input  logic              issue_valid,
    input  logic              issue_has_dest,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              issue_ready,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [XLEN-1:0]   write_data,
    input  logic              flush,
    output logic              wb_underflow
);

    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic              underflow_q, underflow_d;

    logic              retire;
    logic              accept;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;

    assign retire = write_enable && (write_reg != '0);

    // A same-cycle retire frees a slot, so a saturated counter can still accept.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_has_dest && (issue_dest != '0) && (pend_q[issue_dest] == PendMax) &&
            !(retire && (write_reg == issue_dest))) begin
            issue_ready = 1'b0;
        end
    end

    assign accept = issue_valid && issue_has_dest && (issue_dest != '0) && issue_ready;

    always_comb begin
        underflow_d = underflow_q;
        inc_vec     = '0;
        dec_vec     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = accept && (issue_dest == ADDR_W'(i));
            dec_vec[i] = retire && (write_reg == ADDR_W'(i));
            pend_d[i]  = pend_q[i];
            if (flush) begin
                pend_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                pend_d[i] = pend_q[i] + PendOne;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (pend_q[i] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - PendOne;
                end
            end
        end
    end

    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
        if (read_reg1 == '0) begin
            read_data1 = '0;
        end else if (retire && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
        if (read_reg2 == '0) begin
            read_data2 = '0;
        end else if (retire && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
    end

    // Hazard drops when this cycle's retire drains the last outstanding write.
    always_comb begin
        hazard1 = (pend_q[read_reg1] != '0) &&
                  !(dec_vec[read_reg1] && !inc_vec[read_reg1] && (pend_q[read_reg1] == PendOne));
        hazard2 = (pend_q[read_reg2] != '0) &&
                  !(dec_vec[read_reg2] && !inc_vec[read_reg2] && (pend_q[read_reg2] == PendOne));
    end

    assign wb_underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            if (retire) begin
                regs_q[write_reg] <= write_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
            underflow_q <= underflow_d;
        end
    end

endmodule
